hdmi_timing_detector: RTL and testbench

Measures the video raster timing of the decoded HDMI stream and declares timing lock once several consecutive frames match. It sits directly downstream of `hdmi_decode` in the `hdmi_clk` domain, next to `hdmi_framebuffer`. It publishes per-frame totals, active sizes and per-pixel coordinates so the framebuffer window can follow the real mode instead of fixed constants.

---
 rtl/hdmi_timing_detector.sv | 253 +++++++++++++++++++++++++
 tb/tb_hdmi_timing_detector.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_detector.sv
`default_nettype none
// ============================================================================
// Module   : hdmi_timing_detector
// Brief    : Measures the HDMI raster timing of each frame and locks once
//            several consecutive frames agree. Also tracks pixel coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module hdmi_timing_detector #(
    parameter int CW            = 12,
    parameter int STABLE_FRAMES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          valid,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          data_valid,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] h_active,
    output logic [CW-1:0] v_total,
    output logic [CW-1:0] v_active,
    output logic          locked,
    output logic          frame_strobe,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
);

    localparam logic [CW-1:0] c_cnt_max = '1;
    localparam logic [3:0]    c_stable  = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;

    logic          r_hsync_q;
    logic          r_vsync_q;
    logic          r_seen_h;
    logic          r_seen_v;
    logic [CW-1:0] r_pix_cnt;
    logic [CW-1:0] r_act_cnt;
    logic [CW-1:0] r_line_cnt;
    logic [CW-1:0] r_act_max;
    logic [CW-1:0] r_act_lines;
    logic [CW-1:0] r_h_ref;
    logic          r_incons;

    logic [CW-1:0] r_cand_h;
    logic [CW-1:0] r_cand_ha;
    logic [CW-1:0] r_cand_v;
    logic [CW-1:0] r_cand_va;
    logic [3:0]    r_match_cnt;

    logic [CW-1:0] r_h_total;
    logic [CW-1:0] r_h_active;
    logic [CW-1:0] r_v_total;
    logic [CW-1:0] r_v_active;
    logic          r_frame_strobe;

    logic          w_hfall;
    logic          w_vfall;
    logic          w_resync;
    logic          w_rec;
    logic          w_first_line;
    logic          w_pix_sat;
    logic [CW-1:0] w_period;
    logic [CW-1:0] w_h_ref_nx;
    logic          w_incons_nx;
    logic [CW-1:0] w_act_max_nx;
    logic [CW-1:0] w_act_lines_nx;
    logic [CW-1:0] w_line_cnt_nx;
    logic          w_eval;
    logic          w_meas_eq;
    logic [3:0]    w_match_plus1;
    logic          w_cand_load;
    logic          w_match_inc;
    logic          w_match_clr;
    logic          w_publish;

    assign w_hfall  = r_hsync_q & ~hsync;
    assign w_vfall  = r_vsync_q & ~vsync;
    // A missing vsync eventually saturates the line count and forces a resync.
    assign w_resync = ~valid | (r_line_cnt == c_cnt_max);

    // Line bookkeeping for the line that closes on this cycle's hfall.
    assign w_rec          = w_hfall & r_seen_h;
    assign w_first_line   = (r_line_cnt == '0);
    assign w_pix_sat      = (r_pix_cnt == c_cnt_max);
    assign w_period       = r_pix_cnt + 1'b1;
    assign w_h_ref_nx     = (w_rec && w_first_line) ? w_period : r_h_ref;
    assign w_incons_nx    = r_incons | (w_rec & (w_pix_sat | (~w_first_line & (w_period != r_h_ref))));
    assign w_act_max_nx   = (w_rec && (r_act_cnt > r_act_max)) ? r_act_cnt : r_act_max;
    assign w_act_lines_nx = (w_rec && (r_act_cnt != '0) && (r_act_lines != c_cnt_max))
                            ? r_act_lines + 1'b1 : r_act_lines;
    assign w_line_cnt_nx  = (w_rec && (r_line_cnt != c_cnt_max)) ? r_line_cnt + 1'b1 : r_line_cnt;

    assign w_eval        = w_vfall & r_seen_v & ~w_resync;
    assign w_meas_eq     = (w_h_ref_nx == r_cand_h) && (w_act_max_nx == r_cand_ha) &&
                           (w_line_cnt_nx == r_cand_v) && (w_act_lines_nx == r_cand_va);
    assign w_match_plus1 = r_match_cnt + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsync_q   <= 1'b1;
            r_vsync_q   <= 1'b1;
            r_seen_h    <= 1'b0;
            r_seen_v    <= 1'b0;
            r_pix_cnt   <= '0;
            r_act_cnt   <= '0;
            r_line_cnt  <= '0;
            r_act_max   <= '0;
            r_act_lines <= '0;
            r_h_ref     <= '0;
            r_incons    <= 1'b0;
        end else begin
            r_hsync_q <= hsync;
            r_vsync_q <= vsync;
            if (w_resync) begin
                r_seen_h    <= 1'b0;
                r_seen_v    <= 1'b0;
                r_pix_cnt   <= '0;
                r_act_cnt   <= '0;
                r_line_cnt  <= '0;
                r_act_max   <= '0;
                r_act_lines <= '0;
                r_h_ref     <= '0;
                r_incons    <= 1'b0;
            end else begin
                if (w_hfall) begin
                    r_pix_cnt <= '0;
                    r_act_cnt <= '0;
                    r_seen_h  <= 1'b1;
                end else begin
                    if (!w_pix_sat) r_pix_cnt <= r_pix_cnt + 1'b1;
                    if (data_valid && (r_act_cnt != c_cnt_max)) r_act_cnt <= r_act_cnt + 1'b1;
                end
                // Frame close wins; the closing line was already folded into the measurement.
                if (w_vfall) begin
                    r_seen_v    <= 1'b1;
                    r_line_cnt  <= '0;
                    r_act_max   <= '0;
                    r_act_lines <= '0;
                    r_h_ref     <= '0;
                    r_incons    <= 1'b0;
                end else begin
                    r_line_cnt  <= w_line_cnt_nx;
                    r_act_max   <= w_act_max_nx;
                    r_act_lines <= w_act_lines_nx;
                    r_h_ref     <= w_h_ref_nx;
                    r_incons    <= w_incons_nx;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_SEARCH;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_cand_load = 1'b0;
        w_match_inc = 1'b0;
        w_match_clr = 1'b0;
        w_publish   = 1'b0;
        if (w_resync) begin
            w_state_nx  = S_SEARCH;
            w_match_clr = 1'b1;
        end else if (w_eval) begin
            case (r_state)
                S_SEARCH: begin
                    if (!w_incons_nx) begin
                        w_cand_load = 1'b1;
                        if (c_stable == 4'd1) begin
                            w_publish  = 1'b1;
                            w_state_nx = S_LOCKED;
                        end else begin
                            w_state_nx = S_VERIFY;
                        end
                    end
                end
                S_VERIFY: begin
                    if (w_incons_nx) begin
                        w_state_nx = S_SEARCH;
                    end else if (w_meas_eq) begin
                        w_match_inc = 1'b1;
                        if (w_match_plus1 >= c_stable) begin
                            w_publish  = 1'b1;
                            w_state_nx = S_LOCKED;
                        end
                    end else begin
                        w_cand_load = 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (w_incons_nx || !w_meas_eq) w_state_nx = S_SEARCH;
                end
                default: w_state_nx = S_SEARCH;
            endcase
        end
    end

    // Published values equal the candidate whenever a publish occurs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cand_h       <= '0;
            r_cand_ha      <= '0;
            r_cand_v       <= '0;
            r_cand_va      <= '0;
            r_match_cnt    <= '0;
            r_h_total      <= '0;
            r_h_active     <= '0;
            r_v_total      <= '0;
            r_v_active     <= '0;
            r_frame_strobe <= 1'b0;
        end else begin
            r_frame_strobe <= w_eval;
            if (w_match_clr) begin
                r_match_cnt <= '0;
            end else if (w_cand_load) begin
                r_match_cnt <= 4'd1;
                r_cand_h    <= w_h_ref_nx;
                r_cand_ha   <= w_act_max_nx;
                r_cand_v    <= w_line_cnt_nx;
                r_cand_va   <= w_act_lines_nx;
            end else if (w_match_inc) begin
                r_match_cnt <= w_match_plus1;
            end
            if (w_publish) begin
                r_h_total  <= w_h_ref_nx;
                r_h_active <= w_act_max_nx;
                r_v_total  <= w_line_cnt_nx;
                r_v_active <= w_act_lines_nx;
            end
        end
    end

    assign h_total      = r_h_total;
    assign h_active     = r_h_active;
    assign v_total      = r_v_total;
    assign v_active     = r_v_active;
    assign locked       = (r_state == S_LOCKED);
    assign frame_strobe = r_frame_strobe;
    assign x            = r_act_cnt;
    assign y            = r_act_lines;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_timing_detector.sv
`default_nettype none
// ============================================================================
// Module   : tb_hdmi_timing_detector
// Brief    : Directed self-checking bench for hdmi_timing_detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hdmi_timing_detector;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b1;
    logic          hsync = 1'b1;
    logic          vsync = 1'b1;
    logic          data_valid = 1'b0;
    logic [CW-1:0] h_total;
    logic [CW-1:0] h_active;
    logic [CW-1:0] v_total;
    logic [CW-1:0] v_active;
    logic          locked;
    logic          frame_strobe;
    logic [CW-1:0] x;
    logic [CW-1:0] y;

    int n_assert = 0;
    int n_fail   = 0;

    logic          s_strobe;
    logic          s_strobe_nx;
    logic          s_locked;
    logic          s_drop_locked;
    logic [CW-1:0] s_x;
    logic [CW-1:0] s_y;

    hdmi_timing_detector #(.CW(CW), .STABLE_FRAMES(4)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .valid        (valid),
        .hsync        (hsync),
        .vsync        (vsync),
        .data_valid   (data_valid),
        .h_total      (h_total),
        .h_active     (h_active),
        .v_total      (v_total),
        .v_active     (v_active),
        .locked       (locked),
        .frame_strobe (frame_strobe),
        .x            (x),
        .y            (y)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One 10-line frame of 20-clock lines; the first cycle is the vfall.
    task automatic run_frame(input int glitch_line, input int drop_line);
        for (int l = 0; l < 10; l++) begin
            int len;
            len = (l == glitch_line) ? 21 : 20;
            for (int c = 0; c < len; c++) begin
                hsync      = (c >= 2);
                vsync      = (l >= 2);
                data_valid = (l >= 2) && (l < 8) && (c >= 4) && (c < 16);
                valid      = !((l == drop_line) && (c == 10));
                if (l == 3 && c == 6) begin
                    s_x = x;
                    s_y = y;
                end
                tick();
                if (l == 0 && c == 0) begin
                    s_strobe = frame_strobe;
                    s_locked = locked;
                end
                if (l == 0 && c == 1) s_strobe_nx = frame_strobe;
                if (l == drop_line && c == 10) s_drop_locked = locked;
            end
        end
        valid      = 1'b1;
        data_valid = 1'b0;
    endtask

    task automatic short_line();
        for (int c = 0; c < 4; c++) begin
            hsync      = (c >= 1);
            vsync      = 1'b1;
            data_valid = 1'b0;
            valid      = 1'b1;
            tick();
        end
    endtask

    task automatic check_mode(input string tag);
        check({tag, "_h_total"},  32'(h_total),  32'd20);
        check({tag, "_h_active"}, 32'(h_active), 32'd12);
        check({tag, "_v_total"},  32'(v_total),  32'd10);
        check({tag, "_v_active"}, 32'(v_active), 32'd6);
    endtask

    initial begin
        // Reset with toggling inputs
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            hsync      = 1'($urandom_range(0, 1));
            vsync      = 1'($urandom_range(0, 1));
            data_valid = 1'($urandom_range(0, 1));
            valid      = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_h_total",  32'(h_total),      32'd0);
        check("rst_h_active", 32'(h_active),     32'd0);
        check("rst_v_total",  32'(v_total),      32'd0);
        check("rst_v_active", 32'(v_active),     32'd0);
        check("rst_locked",   32'(locked),       32'd0);
        check("rst_strobe",   32'(frame_strobe), 32'd0);
        check("rst_x",        32'(x),            32'd0);
        check("rst_y",        32'(y),            32'd0);

        hsync = 1'b1; vsync = 1'b1; data_valid = 1'b0; valid = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Lock acquisition: vfall 1 is discarded, 2..5 evaluated
        run_frame(-1, -1);
        check("vf1_strobe", 32'(s_strobe), 32'd0);
        run_frame(-1, -1);
        check("vf2_strobe", 32'(s_strobe), 32'd1);
        check("vf2_strobe_pulse", 32'(s_strobe_nx), 32'd0);
        run_frame(-1, -1);
        check("vf3_strobe", 32'(s_strobe), 32'd1);
        run_frame(-1, -1);
        check("vf4_strobe", 32'(s_strobe), 32'd1);
        check("vf4_locked", 32'(s_locked), 32'd0);
        run_frame(-1, -1);
        check("vf5_strobe", 32'(s_strobe), 32'd1);
        check("vf5_locked", 32'(s_locked), 32'd1);
        check("coord_x", 32'(s_x), 32'd2);
        check("coord_y", 32'(s_y), 32'd1);
        check_mode("lock");

        // Line glitch in the frame closed by vfall 7
        run_frame(3, -1);
        run_frame(-1, -1);
        check("glitch_locked", 32'(s_locked), 32'd0);
        check("glitch_strobe", 32'(s_strobe), 32'd1);
        check_mode("glitch");
        run_frame(-1, -1);
        run_frame(-1, -1);
        run_frame(-1, -1);
        check("glitch_vf10_locked", 32'(s_locked), 32'd0);
        run_frame(-1, -1);
        check("glitch_relock", 32'(s_locked), 32'd1);

        // One-cycle valid drop while locked
        run_frame(-1, 5);
        check("drop_locked", 32'(s_drop_locked), 32'd0);
        check("drop_h_total", 32'(h_total), 32'd20);
        check("drop_v_active", 32'(v_active), 32'd6);
        run_frame(-1, -1);
        check("drop_vf1_strobe", 32'(s_strobe), 32'd0);
        run_frame(-1, -1);
        run_frame(-1, -1);
        run_frame(-1, -1);
        check("drop_vf4_locked", 32'(s_locked), 32'd0);
        run_frame(-1, -1);
        check("drop_relock", 32'(s_locked), 32'd1);

        // Vsync timeout: 9 lines already counted in this frame
        run_frame(-1, -1);
        check("pre_timeout_locked", 32'(s_locked), 32'd1);
        for (int i = 0; i < 4085; i++) short_line();
        check("timeout_4094_locked", 32'(locked), 32'd1);
        short_line();
        check("timeout_4095_locked", 32'(locked), 32'd0);
        check("timeout_h_total", 32'(h_total), 32'd20);
        run_frame(-1, -1);
        check("timeout_vf1_strobe", 32'(s_strobe), 32'd0);
        run_frame(-1, -1);
        check("timeout_vf2_strobe", 32'(s_strobe), 32'd1);
        check("timeout_vf2_locked", 32'(s_locked), 32'd0);

        // Relock, then asynchronous reset mid-frame
        run_frame(-1, -1);
        run_frame(-1, -1);
        run_frame(-1, -1);
        check("final_locked", 32'(s_locked), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_locked",   32'(locked),   32'd0);
        check("async_h_total",  32'(h_total),  32'd0);
        check("async_v_active", 32'(v_active), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
